// File: rtl/botoes_condicionador.sv
// Conditions the four raw push-buttons for the memory game: two-flop synchroniser, whole-vector debounce,
// and a small FSM that passes on single presses only and flags multi-button presses.
module botoes_condicionador #(
  parameter int N_BOTOES        = 4,
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes_brutos,
  output logic [N_BOTOES-1:0] botoes,
  output logic                jogada_pulso,
  output logic                invalida,
  output logic [3:0]          db_estado
);

  localparam int CW = (DEBOUNCE_CICLOS > 2) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CW-1:0] CONT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [1:0] {
    OCIOSO      = 2'd0,
    PRESSIONADO = 2'd1,
    MULTIPLO    = 2'd2
  } estado_t;

  logic [N_BOTOES-1:0] s1, sinc, anterior, estavel;
  logic [CW-1:0]       contagem;
  estado_t             estado, estado_prox;
  logic [N_BOTOES-1:0] botoes_prox;
  logic                jogada_prox, invalida_prox;

  function automatic logic um_bit(input logic [N_BOTOES-1:0] v);
    return (v != '0) && ((v & (v - N_BOTOES'(1))) == '0);
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1       <= '0;
      sinc     <= '0;
      anterior <= '0;
    end else begin
      s1       <= botoes_brutos;
      sinc     <= s1;
      anterior <= sinc;
    end
  end

  // Any change of the synchronised vector restarts the count; the count saturates, never wraps.
  always_ff @(posedge clock) begin
    if (!reset) begin
      contagem <= '0;
      estavel  <= '0;
    end else if (sinc != anterior) begin
      contagem <= '0;
    end else if (contagem != CONT_MAX) begin
      contagem <= contagem + CW'(1);
    end else begin
      estavel <= sinc;
    end
  end

  always_comb begin
    estado_prox   = estado;
    botoes_prox   = botoes;
    jogada_prox   = 1'b0;
    invalida_prox = 1'b0;
    case (estado)
      OCIOSO: begin
        botoes_prox = '0;
        if (estavel == '0) begin
          estado_prox = OCIOSO;
        end else if (um_bit(estavel)) begin
          estado_prox = PRESSIONADO;
          botoes_prox = estavel;
          jogada_prox = 1'b1;
        end else begin
          estado_prox   = MULTIPLO;
          invalida_prox = 1'b1;
        end
      end
      PRESSIONADO: begin
        if (estavel == botoes) begin
          estado_prox = PRESSIONADO;
        end else if (estavel == '0) begin
          estado_prox = OCIOSO;
          botoes_prox = '0;
        end else begin
          estado_prox   = MULTIPLO;
          botoes_prox   = '0;
          invalida_prox = 1'b1;
        end
      end
      MULTIPLO: begin
        botoes_prox = '0;
        if (estavel == '0) begin
          estado_prox = OCIOSO;
        end else begin
          estado_prox = MULTIPLO;
        end
      end
      default: begin
        estado_prox = OCIOSO;
        botoes_prox = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado       <= OCIOSO;
      botoes       <= '0;
      jogada_pulso <= 1'b0;
      invalida     <= 1'b0;
    end else begin
      estado       <= estado_prox;
      botoes       <= botoes_prox;
      jogada_pulso <= jogada_prox;
      invalida     <= invalida_prox;
    end
  end

  assign db_estado = {2'b00, estado};

endmodule

// File: tb/tb_botoes_condicionador.sv
// Directed bench for botoes_condicionador with DEBOUNCE_CICLOS=4 (press-to-output latency of 8 rising edges
// counted from the first edge that samples the new raw level).
module tb_botoes_condicionador;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] botoes_brutos;
  logic [3:0] botoes;
  logic       jogada_pulso;
  logic       invalida;
  logic [3:0] db_estado;

  int vectors = 0;
  int errors  = 0;
  int n_pulsos = 0;
  int n_invalidas = 0;
  int p0, i0;

  botoes_condicionador #(.N_BOTOES(4), .DEBOUNCE_CICLOS(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .botoes_brutos(botoes_brutos),
    .botoes       (botoes),
    .jogada_pulso (jogada_pulso),
    .invalida     (invalida),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (jogada_pulso === 1'b1) n_pulsos = n_pulsos + 1;
    if (invalida === 1'b1) n_invalidas = n_invalidas + 1;
  end

  task automatic edges(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] b, input logic p, input logic inv, input logic [3:0] st);
    chk({tag, ".botoes"}, 32'(botoes), 32'(b));
    chk({tag, ".pulso"}, 32'(jogada_pulso), 32'(p));
    chk({tag, ".invalida"}, 32'(invalida), 32'(inv));
    chk({tag, ".estado"}, 32'(db_estado), 32'(st));
  endtask

  initial begin
    // reset held for 2 edges while a button is already down
    reset = 1'b0;
    botoes_brutos = 4'b0010;
    edges(2);
    chk_out("reset", 4'b0000, 1'b0, 1'b0, 4'd0);
    reset = 1'b1;
    edges(7);
    chk_out("reset_lat7", 4'b0000, 1'b0, 1'b0, 4'd0);
    edges(1);
    chk_out("reset_press", 4'b0010, 1'b1, 1'b0, 4'd1);
    botoes_brutos = 4'b0000;
    edges(8);
    chk_out("reset_release", 4'b0000, 1'b0, 1'b0, 4'd0);

    // clean press and release
    p0 = n_pulsos;
    botoes_brutos = 4'b0100;
    edges(7);
    chk_out("clean_lat7", 4'b0000, 1'b0, 1'b0, 4'd0);
    edges(1);
    chk_out("clean_press", 4'b0100, 1'b1, 1'b0, 4'd1);
    edges(1);
    chk_out("clean_hold", 4'b0100, 1'b0, 1'b0, 4'd1);
    botoes_brutos = 4'b0000;
    edges(7);
    chk_out("clean_rel7", 4'b0100, 1'b0, 1'b0, 4'd1);
    edges(1);
    chk_out("clean_rel8", 4'b0000, 1'b0, 1'b0, 4'd0);
    edges(2);
    chk("clean_npulse", 32'(n_pulsos - p0), 32'd1);

    // bounce: toggle every 2 cycles, last toggle high, then held
    p0 = n_pulsos;
    for (int k = 0; k < 5; k++) begin
      botoes_brutos = (k % 2 == 0) ? 4'b0001 : 4'b0000;
      edges(2);
    end
    edges(5);
    chk_out("bounce_lat7", 4'b0000, 1'b0, 1'b0, 4'd0);
    edges(1);
    chk_out("bounce_press", 4'b0001, 1'b1, 1'b0, 4'd1);
    botoes_brutos = 4'b0000;
    edges(8);
    chk_out("bounce_rel", 4'b0000, 1'b0, 1'b0, 4'd0);
    edges(2);
    chk("bounce_npulse", 32'(n_pulsos - p0), 32'd1);

    // glitch shorter than the filter window
    p0 = n_pulsos;
    i0 = n_invalidas;
    botoes_brutos = 4'b1000;
    edges(3);
    botoes_brutos = 4'b0000;
    edges(5);
    chk_out("glitch_mid", 4'b0000, 1'b0, 1'b0, 4'd0);
    edges(8);
    chk_out("glitch_end", 4'b0000, 1'b0, 1'b0, 4'd0);
    chk("glitch_npulse", 32'(n_pulsos - p0), 32'd0);
    chk("glitch_ninval", 32'(n_invalidas - i0), 32'd0);

    // multi-button press from idle
    p0 = n_pulsos;
    i0 = n_invalidas;
    botoes_brutos = 4'b0011;
    edges(7);
    chk_out("multi_lat7", 4'b0000, 1'b0, 1'b0, 4'd0);
    edges(1);
    chk_out("multi_det", 4'b0000, 1'b0, 1'b1, 4'd2);
    edges(1);
    chk_out("multi_hold", 4'b0000, 1'b0, 1'b0, 4'd2);
    botoes_brutos = 4'b0000;
    edges(8);
    chk_out("multi_rel", 4'b0000, 1'b0, 1'b0, 4'd0);
    edges(2);
    chk("multi_npulse", 32'(n_pulsos - p0), 32'd0);
    chk("multi_ninval", 32'(n_invalidas - i0), 32'd1);

    // second button added while one is held
    botoes_brutos = 4'b0001;
    edges(8);
    chk_out("add_press", 4'b0001, 1'b1, 1'b0, 4'd1);
    edges(2);
    p0 = n_pulsos;
    botoes_brutos = 4'b0101;
    edges(7);
    chk_out("add_lat7", 4'b0001, 1'b0, 1'b0, 4'd1);
    edges(1);
    chk_out("add_det", 4'b0000, 1'b0, 1'b1, 4'd2);
    edges(1);
    chk_out("add_after", 4'b0000, 1'b0, 1'b0, 4'd2);
    botoes_brutos = 4'b0001;
    edges(8);
    chk_out("add_partial_rel", 4'b0000, 1'b0, 1'b0, 4'd2);
    chk("add_npulse", 32'(n_pulsos - p0), 32'd0);
    botoes_brutos = 4'b0000;
    edges(8);
    chk_out("add_full_rel", 4'b0000, 1'b0, 1'b0, 4'd0);
    botoes_brutos = 4'b0001;
    edges(8);
    chk_out("add_repress", 4'b0001, 1'b1, 1'b0, 4'd1);

    // reset mid-press: held button is re-filtered and pulses again
    reset = 1'b0;
    edges(1);
    chk_out("midreset", 4'b0000, 1'b0, 1'b0, 4'd0);
    reset = 1'b1;
    edges(7);
    chk_out("midreset_lat7", 4'b0000, 1'b0, 1'b0, 4'd0);
    edges(1);
    chk_out("midreset_press", 4'b0001, 1'b1, 1'b0, 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/botoes_condicionador.md
# botoes_condicionador

Input-conditioning stage placed directly upstream of the memory-game top level. It synchronises the four raw push-buttons and debounces them as one vector. It accepts only single-button presses and delivers a clean, held one-hot `botoes` vector plus a one-cycle `jogada_pulso` to the game's `botoes` input. Multi-button presses are reported on `invalida` and never reach the game.

## Interface
- `N_BOTOES`, 4: number of buttons; fixed at 4 in this design.
- `DEBOUNCE_CICLOS`, 50000: stable cycles required before a vector change is accepted (1 ms at 50 MHz); legal minimum 2.

- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-low. `reset`=0 at a rising edge clears all state.
- `botoes_brutos` in 4: raw, asynchronous, bouncing button levels; 1 = pressed.
- `botoes` out 4: clean one-hot button level, held for the whole accepted press; 0 otherwise.
- `jogada_pulso` out 1: one-cycle pulse on acceptance of a single-button press.
- `invalida` out 1: one-cycle pulse when a stable multi-button vector is detected.
- `db_estado` out 4: FSM state code for hex display.

## Operation
- Synchroniser: two flops per bit, `s1` then `sinc`. No logic between the flops.
- Debounce filter, on the whole vector:
  - `anterior` <= `sinc` every cycle.
  - If `sinc` != `anterior`, `contagem` <= 0.
  - Else if `contagem` != DEBOUNCE_CICLOS-1, `contagem` += 1.
  - Else, `estavel` <= `sinc`. `contagem` saturates and never wraps.
  - `contagem` width is ceil(log2(DEBOUNCE_CICLOS)).
- FSM states and codes:
  - OCIOSO=0: `estavel`=0 → stay. `estavel` one-hot → PRESSIONADO: `botoes`<=`estavel`, `jogada_pulso`<=1. `estavel` with ≥2 bits set → MULTIPLO: `invalida`<=1.
  - PRESSIONADO=1: `estavel`==`botoes` → stay. `estavel`=0 → OCIOSO: `botoes`<=0. Any other nonzero value → MULTIPLO: `botoes`<=0, `invalida`<=1.
  - MULTIPLO=2: `botoes`=0. Stay until `estavel`=0, then OCIOSO. No pulses are emitted in this state.
  - Unused codes → OCIOSO.
- All outputs are registered.
- Reset values: `botoes`=0, `jogada_pulso`=0, `invalida`=0, `db_estado`=0. Internal `s1`, `sinc`, `anterior`, `estavel` and `contagem` are all 0; FSM is in OCIOSO.
- Reset mid-press: the block returns to OCIOSO with `estavel`=0. A button still held afterwards is re-filtered and produces a fresh `jogada_pulso` after the full latency. This is intended; a press is never lost across reset.
- `jogada_pulso` and `invalida` are never high in the same cycle.
- Each accepted press yields exactly one `jogada_pulso`.

## Timing
- Press latency: a raw step first sampled by `s1` at edge 0, and held stable, appears on `botoes` and `jogada_pulso` after edge DEBOUNCE_CICLOS+3.
  - Edge 1: `sinc`.
  - Edge 2: mismatch detected, `contagem` cleared.
  - Edge DEBOUNCE_CICLOS+1: `contagem` reaches DEBOUNCE_CICLOS-1.
  - Edge DEBOUNCE_CICLOS+2: `estavel` updated.
  - Edge DEBOUNCE_CICLOS+3: FSM outputs update.
- Release latency: identical, DEBOUNCE_CICLOS+3 edges to `botoes`=0.
- `jogada_pulso` is high for exactly one cycle. `botoes` stays valid while it is high and afterwards until release.
- Glitch rejection: any `sinc` change lasting fewer than DEBOUNCE_CICLOS cycles never updates `estavel`.
- Every `sinc` change restarts the count, so bounce extends latency by the bounce duration.
- Second button added while one is held: after the filter, `botoes` drops to 0 in the same cycle `invalida` pulses. No new `jogada_pulso` until all buttons are released and a fresh single press is accepted.

## Test plan
All scenarios use DEBOUNCE_CICLOS=4.
- Reset: `reset`=0 for 2 edges with `botoes_brutos`=4'b0010 → all outputs 0, `db_estado`=0. After `reset`=1, a pulse follows 7 edges later.
- Clean press: `botoes_brutos` 0→4'b0100 sampled at edge 0 → `botoes`=4'b0100 and `jogada_pulso`=1 after edge 7 only. `jogada_pulso`=0 after edge 8 while `botoes` holds. Release → `botoes`=0 seven edges later; no pulse.
- Bounce: 4'b0001 toggled high/low every 2 cycles for 10 cycles, then held → exactly one `jogada_pulso`, 7 edges after the last toggle is sampled.
- Glitch: 4'b1000 high for 3 cycles then 0 → `botoes`, `jogada_pulso`, `invalida` stay 0; `db_estado` stays 0.
- Multi-press from idle: 4'b0011 held → `invalida`=1 for one cycle after edge 7, `db_estado`=2, `botoes`=0. Release to 0 → OCIOSO without a pulse.
- Add button while held: accept 4'b0001, then go to 4'b0101 → `botoes`=0 and `invalida` pulse 7 edges later. Release to 4'b0001 → still MULTIPLO, no pulse. Release to 0 then press 4'b0001 → new `jogada_pulso`.
